reorder_buffer: RTL and testbench

//  In-order retirement buffer directly downstream of register rename.
//  - Takes one renamed instruction per cycle; records arch dest, new phys dest and the previous phys mapping.
//  - Tracks out-of-order completion from execute.
//  - Retires at most one entry per cycle in program order.
//  - Each retirement that has a destination returns the previous phys tag to rename's free list (commit_valid/commit_phys).

---
 rtl/reorder_buffer.sv | 135 +++++++++++++
 tb/tb_reorder_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer behind register rename: tracks out-of-order completion and
// retires one entry per cycle. Define ROB_EXC_FLUSH_EN to flush the pipeline on an excepting head.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PTAG_W = 6,
  parameter int AREG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_has_dest,
  input  logic [AREG_W-1:0] alloc_arch_dest,
  input  logic [PTAG_W-1:0] alloc_phys_dest,
  input  logic [PTAG_W-1:0] alloc_old_phys,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,
  input  logic              complete_exc,
  output logic              retire_valid,
  output logic [AREG_W-1:0] retire_arch_dest,
  output logic [PTAG_W-1:0] retire_phys_dest,
  output logic              commit_valid,
  output logic [PTAG_W-1:0] commit_phys,
  output logic              flush,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_done;
  logic [DEPTH-1:0]  ent_has_dest;
  logic [AREG_W-1:0] ent_arch [DEPTH];
  logic [PTAG_W-1:0] ent_phys [DEPTH];
  logic [PTAG_W-1:0] ent_old  [DEPTH];
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count_q;
  logic              alloc_fire;
  logic              retire_now;
  logic              flush_pending;

`ifdef ROB_EXC_FLUSH_EN
  logic [DEPTH-1:0] ent_exc;
  assign flush_pending = retire_now & ent_exc[head];
`else
  logic unused_exc;
  assign unused_exc    = complete_exc;
  assign flush_pending = 1'b0;
`endif

  // Handshake: an instruction is accepted on a rising edge where alloc_valid & alloc_ready;
  // alloc_ready depends only on registered state, so a same-cycle retire never frees the slot.
  assign alloc_ready = (count_q != FULL) & ~flush_pending;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_tag   = tail;
  assign retire_now  = ent_valid[head] & ent_done[head];
  assign count       = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head             <= '0;
      tail             <= '0;
      count_q          <= '0;
      ent_valid        <= '0;
      ent_done         <= '0;
`ifdef ROB_EXC_FLUSH_EN
      ent_exc          <= '0;
`endif
      retire_valid     <= 1'b0;
      retire_arch_dest <= '0;
      retire_phys_dest <= '0;
      commit_valid     <= 1'b0;
      commit_phys      <= '0;
      flush            <= 1'b0;
    end else begin
      retire_valid     <= retire_now;
      retire_arch_dest <= retire_now ? ent_arch[head] : '0;
      retire_phys_dest <= retire_now ? ent_phys[head] : '0;
      commit_valid     <= retire_now & ent_has_dest[head];
      commit_phys      <= (retire_now & ent_has_dest[head]) ? ent_old[head] : '0;
      flush            <= 1'b0;

      // A slot being allocated this cycle is not yet valid, so its completion drops here.
      if (complete_valid && ent_valid[complete_tag]) begin
        ent_done[complete_tag] <= 1'b1;
`ifdef ROB_EXC_FLUSH_EN
        ent_exc[complete_tag]  <= complete_exc;
`endif
      end

      if (retire_now) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end

      if (alloc_fire) begin
        ent_valid[tail]    <= 1'b1;
        ent_done[tail]     <= 1'b0;
`ifdef ROB_EXC_FLUSH_EN
        ent_exc[tail]      <= 1'b0;
`endif
        ent_has_dest[tail] <= alloc_has_dest;
        ent_arch[tail]     <= alloc_arch_dest;
        ent_phys[tail]     <= alloc_phys_dest;
        ent_old[tail]      <= alloc_old_phys;
        tail               <= tail + 1'b1;
      end

      case ({alloc_fire, retire_now})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

`ifdef ROB_EXC_FLUSH_EN
      // Excepting head: younger entries are squashed and the old mapping is not freed.
      if (flush_pending) begin
        commit_valid <= 1'b0;
        commit_phys  <= '0;
        flush        <= 1'b1;
        ent_valid    <= '0;
        ent_done     <= '0;
        ent_exc      <= '0;
        head         <= '0;
        tail         <= '0;
        count_q      <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a scoreboard queue holds the expected retire record of
// every accepted instruction in program order and is compared on each retire pulse.
module tb_reorder_buffer;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int PTAG_W = 6;
  localparam int AREG_W = 5;
  localparam int W      = 1 + AREG_W + PTAG_W + 1 + PTAG_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_has_dest;
  logic [AREG_W-1:0] alloc_arch_dest;
  logic [PTAG_W-1:0] alloc_phys_dest;
  logic [PTAG_W-1:0] alloc_old_phys;
  logic [TAG_W-1:0]  alloc_tag;
  logic              complete_valid;
  logic [TAG_W-1:0]  complete_tag;
  logic              complete_exc;
  logic              retire_valid;
  logic [AREG_W-1:0] retire_arch_dest;
  logic [PTAG_W-1:0] retire_phys_dest;
  logic              commit_valid;
  logic [PTAG_W-1:0] commit_phys;
  logic              flush;
  logic [TAG_W:0]    count;

  // record layout: {flush, arch, phys, commit_valid, commit_phys}
  logic [W-1:0]     exp_q[$];
  logic [TAG_W-1:0] tag_q[$];
  logic [TAG_W-1:0] tb_tail;
  int tests = 0;
  int fails = 0;
  int n_ret = 0;
  int base;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PTAG_W(PTAG_W), .AREG_W(AREG_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_has_dest(alloc_has_dest),
    .alloc_arch_dest(alloc_arch_dest), .alloc_phys_dest(alloc_phys_dest),
    .alloc_old_phys(alloc_old_phys), .alloc_tag(alloc_tag),
    .complete_valid(complete_valid), .complete_tag(complete_tag), .complete_exc(complete_exc),
    .retire_valid(retire_valid), .retire_arch_dest(retire_arch_dest),
    .retire_phys_dest(retire_phys_dest), .commit_valid(commit_valid),
    .commit_phys(commit_phys), .flush(flush), .count(count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    obs = {flush, retire_arch_dest, retire_phys_dest, commit_valid, commit_phys};
    if (retire_valid) begin
      n_ret++;
      if (exp_q.size() == 0) begin
        chk("unexpected_retire", 32'(obs), 32'(~obs));
      end else begin
        exp = exp_q.pop_front();
        chk("retire_record", 32'(obs), 32'(exp));
        if (exp[W-1]) begin
          exp_q.delete();
          tb_tail = '0;
        end
      end
    end else begin
      chk("idle_outputs_zero", 32'(obs), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    alloc_valid    = 1'b0;
    complete_valid = 1'b0;
    complete_exc   = 1'b0;
    monitor();
  endtask

  task automatic drive_alloc(input logic hd, input logic [AREG_W-1:0] a,
                             input logic [PTAG_W-1:0] p, input logic [PTAG_W-1:0] o);
    chk("alloc_tag", 32'(alloc_tag), 32'(tb_tail));
    alloc_valid     = 1'b1;
    alloc_has_dest  = hd;
    alloc_arch_dest = a;
    alloc_phys_dest = p;
    alloc_old_phys  = o;
    if (alloc_ready) begin
      exp_q.push_back({1'b0, a, p, hd, hd ? o : {PTAG_W{1'b0}}});
      tag_q.push_back(tb_tail);
      tb_tail++;
    end
  endtask

  task automatic drive_complete(input logic [TAG_W-1:0] t, input logic exc);
    complete_valid = 1'b1;
    complete_tag   = t;
    complete_exc   = exc;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && count != 0; k++) tick();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [TAG_W-1:0] t0, t1, tmp;
    int j;
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_has_dest = 1'b0; alloc_arch_dest = '0;
    alloc_phys_dest = '0; alloc_old_phys = '0;
    complete_valid = 1'b0; complete_tag = '0; complete_exc = 1'b0;
    tb_tail = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ready", 32'(alloc_ready), 32'd1);
    chk("reset_tag", 32'(alloc_tag), 32'd0);
    chk("reset_retire", 32'(retire_valid), 32'd0);
    drive_complete(4'd5, 1'b0);
    tick();
    tick();
    chk("stray_complete_count", 32'(count), 32'd0);

    // out-of-order completion, in-order retire
    for (int i = 0; i < 3; i++) begin
      drive_alloc(1'b1, 5'(i + 1), 6'(32 + i), 6'(i + 1));
      tick();
    end
    chk("three_count", 32'(count), 32'd3);
    base = n_ret;
    drive_complete(4'd2, 1'b0); tick();
    drive_complete(4'd0, 1'b0); tick();
    chk("no_early_retire", n_ret, base);
    drive_complete(4'd1, 1'b0); tick();
    chk("retire0", n_ret, base + 1);
    tick();
    chk("retire1", n_ret, base + 2);
    tick();
    chk("retire2", n_ret, base + 3);
    chk("three_empty", 32'(count), 32'd0);
    tag_q.delete();

    // fill, full backpressure, wrap
    for (int i = 0; i < DEPTH; i++) begin
      drive_alloc(1'b1, 5'(i), 6'(i + 8), 6'(i + 40));
      tick();
    end
    chk("full_count", 32'(count), 32'd16);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    drive_alloc(1'b1, 5'd31, 6'd63, 6'd62);
    tick();
    chk("full_blocked", 32'(count), 32'd16);
    base = n_ret;
    drive_complete(tag_q.pop_front(), 1'b0);
    tick();
    chk("full_ready_hold", 32'(alloc_ready), 32'd0);
    chk("full_no_retire", n_ret, base);
    tick();
    chk("full_head_retire", n_ret, base + 1);
    chk("full_ready_back", 32'(alloc_ready), 32'd1);
    chk("full_count15", 32'(count), 32'd15);
    drive_alloc(1'b1, 5'd30, 6'd61, 6'd60);
    tick();
    chk("refill_count", 32'(count), 32'd16);
    for (int i = tag_q.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = tag_q[i]; tag_q[i] = tag_q[j]; tag_q[j] = tmp;
    end
    for (int i = 0; i < tag_q.size(); i++) begin
      drive_complete(tag_q[i], 1'b0);
      tick();
    end
    drain();
    tag_q.delete();

    // steady alloc+retire at count=1
    drive_alloc(1'b1, 5'd7, 6'd20, 6'd21); tick();
    drive_complete(tag_q.pop_front(), 1'b0); tick();
    chk("steady_prime", 32'(count), 32'd1);
    for (int i = 0; i < 20; i++) begin
      base = n_ret;
      drive_alloc((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      tick();
      chk("steady_retire", n_ret, base + 1);
      chk("steady_count_a", 32'(count), 32'd1);
      if (i == 1) begin
        chk("nodest_retire", 32'(retire_valid), 32'd1);
        chk("nodest_commit", 32'(commit_valid), 32'd0);
      end
      drive_complete(tag_q.pop_front(), 1'b0);
      tick();
      chk("steady_count_b", 32'(count), 32'd1);
    end
    tick();
    chk("steady_empty", 32'(count), 32'd0);

    // exception on the second of four entries
    for (int i = 0; i < 4; i++) begin
      drive_alloc(1'b1, 5'(10 + i), 6'(50 + i), 6'(20 + i));
      tick();
    end
    t0 = tag_q[0];
    t1 = tag_q[1];
    base = n_ret;
    drive_complete(t1, 1'b1); tick();
`ifdef ROB_EXC_FLUSH_EN
    exp_q[1] = {1'b1, 5'd11, 6'd51, 1'b0, 6'd0};
`endif
    drive_complete(t0, 1'b0); tick();
    chk("exc_no_early", n_ret, base);
    tick();
    chk("exc_tag0_retire", n_ret, base + 1);
`ifdef ROB_EXC_FLUSH_EN
    chk("exc_ready_blocked", 32'(alloc_ready), 32'd0);
    tick();
    chk("exc_flush_retire", n_ret, base + 2);
    chk("exc_flush", 32'(flush), 32'd1);
    chk("exc_count", 32'(count), 32'd0);
    chk("exc_tag_zero", 32'(alloc_tag), 32'd0);
    chk("exc_ready_back", 32'(alloc_ready), 32'd1);
`else
    tick();
    chk("exc_normal_retire", n_ret, base + 2);
    drive_complete(tag_q[2], 1'b0); tick();
    drive_complete(tag_q[3], 1'b1); tick();
    drain();
`endif
    tag_q.delete();

    // reset with live entries
    for (int i = 0; i < 5; i++) begin
      drive_alloc(1'b1, 5'(20 + i), 6'(i + 1), 6'(30 + i));
      tick();
    end
    drive_complete(tag_q[2], 1'b0); tick();
    drive_complete(tag_q[4], 1'b0); tick();
    chk("live_count", 32'(count), 32'd5);
    rst = 1'b1;
    exp_q.delete();
    drive_complete(tag_q[0], 1'b0);
    tick();
    rst = 1'b0;
    tb_tail = '0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_tag", 32'(alloc_tag), 32'd0);
    chk("midrst_ready", 32'(alloc_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive_complete(tag_q[i], 1'b0);
      tick();
    end
    tick();
    chk("post_rst_count", 32'(count), 32'd0);
    tag_q.delete();
    drive_alloc(1'b1, 5'd3, 6'd44, 6'd45); tick();
    drive_complete(tag_q.pop_front(), 1'b0); tick();
    tick();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
